// File: rtl/abs_dif_pkg.sv
// Shared constants and a reference absolute-difference helper for the abs_dif block.
package abs_dif_pkg;

   localparam int unsigned DEF_WIDTH = 4;
   localparam int unsigned MAX_WIDTH = 32;

   // Operands are zero-extended to MAX_WIDTH by the caller; result is |a - b|.
   function automatic logic [MAX_WIDTH-1:0] abs_diff(input logic [MAX_WIDTH-1:0] a,
                                                     input logic [MAX_WIDTH-1:0] b);
      if (a >= b) return a - b;
      else        return b - a;
   endfunction

endpackage

// File: rtl/abs_dif_core.sv
// Combinational |a - b| with borrow-derived less-than flag and equality flag.
module abs_dif_core
   import abs_dif_pkg::*;
#(
   parameter int unsigned WIDTH = DEF_WIDTH
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] diff,
   output logic             a_lt_b,
   output logic             eq
);

   logic [WIDTH:0]   d;
   logic             borrow;
   logic [WIDTH-1:0] b_minus_a;

   // One extra bit on the subtraction exposes the borrow, which doubles as a < b.
   assign d         = {1'b0, a} - {1'b0, b};
   assign borrow    = d[WIDTH];
   assign b_minus_a = b - a;

   assign diff   = borrow ? b_minus_a : d[WIDTH-1:0];
   assign a_lt_b = borrow;
   assign eq     = (a == b);

endmodule

// File: rtl/abs_dif.sv
// One-cycle registered absolute-difference stage with valid strobe and compare flags.
module abs_dif
   import abs_dif_pkg::*;
#(
   parameter int unsigned WIDTH = DEF_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] out,
   output logic             out_valid,
   output logic             a_lt_b,
   output logic             eq
);

   logic [WIDTH-1:0] diff_p0;
   logic             lt_p0;
   logic             eq_p0;

   abs_dif_core #(
      .WIDTH (WIDTH)
   ) u_core (
      .a      (a),
      .b      (b),
      .diff   (diff_p0),
      .a_lt_b (lt_p0),
      .eq     (eq_p0)
   );

   // p0 -> p1: result registers load only on accepted pairs, so idle inputs never leak through.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out       <= '0;
         a_lt_b    <= 1'b0;
         eq        <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         out_valid <= in_valid;
         if (in_valid) begin
            out    <= diff_p0;
            a_lt_b <= lt_p0;
            eq     <= eq_p0;
         end
      end
   end

endmodule

// File: tb/tb_abs_dif.sv
// Directed plus randomized bench for abs_dif against an arithmetic reference model.
module tb_abs_dif;
   import abs_dif_pkg::*;

   localparam int unsigned W   = 4;
   localparam int unsigned MAX = (1 << W) - 1;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         in_valid;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic [W-1:0] out;
   logic         out_valid;
   logic         a_lt_b;
   logic         eq;

   int compared   = 0;
   int mismatched = 0;

   logic [W-1:0] m_out;
   logic         m_vld;
   logic         m_lt;
   logic         m_eq;

   abs_dif #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .a         (a),
      .b         (b),
      .out       (out),
      .out_valid (out_valid),
      .a_lt_b    (a_lt_b),
      .eq        (eq)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic int ref_abs(input int x, input int y);
      return (x > y) ? (x - y) : (y - x);
   endfunction

   task automatic check_all(input string tag);
      compared++;
      assert (out === m_out) else begin
         mismatched++;
         $error("FAIL %s out: observed %0d expected %0d", tag, out, m_out);
      end
      compared++;
      assert (out_valid === m_vld) else begin
         mismatched++;
         $error("FAIL %s out_valid: observed %0b expected %0b", tag, out_valid, m_vld);
      end
      compared++;
      assert (a_lt_b === m_lt) else begin
         mismatched++;
         $error("FAIL %s a_lt_b: observed %0b expected %0b", tag, a_lt_b, m_lt);
      end
      compared++;
      assert (eq === m_eq) else begin
         mismatched++;
         $error("FAIL %s eq: observed %0b expected %0b", tag, eq, m_eq);
      end
   endtask

   // Called at a falling edge: drive, take the rising edge, update model, check at next fall.
   task automatic cycle(input logic v, input logic [W-1:0] av, input logic [W-1:0] bv,
                        input string tag);
      in_valid = v;
      a        = av;
      b        = bv;
      @(posedge clk);
      m_vld = v;
      if (v) begin
         m_out = W'(ref_abs(int'(av), int'(bv)));
         m_lt  = (int'(av) < int'(bv));
         m_eq  = (int'(av) == int'(bv));
      end
      @(negedge clk);
      check_all(tag);
   endtask

   task automatic model_reset();
      m_out = '0;
      m_vld = 1'b0;
      m_lt  = 1'b0;
      m_eq  = 1'b0;
   endtask

   initial begin
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      logic [MAX_WIDTH-1:0] pkg_val;

      // Reset held with live random inputs.
      rst_n    = 1'b0;
      in_valid = 1'b1;
      a        = W'($urandom);
      b        = W'($urandom);
      model_reset();
      repeat (3) begin
         @(negedge clk);
         a = W'($urandom);
         b = W'($urandom);
         check_all("reset_hold");
      end
      rst_n    = 1'b1;
      in_valid = 1'b0;

      // Directed arithmetic and boundary cases.
      cycle(1'b1, 4'd3,  4'd12, "a3_b12");
      cycle(1'b1, 4'd10, 4'd4,  "a10_b4");
      cycle(1'b1, 4'd5,  4'd5,  "a5_b5");
      cycle(1'b1, 4'd12, 4'd0,  "a12_b0");
      cycle(1'b1, 4'd0,  W'(MAX), "a0_bmax");
      cycle(1'b1, W'(MAX), W'(MAX), "amax_bmax");
      cycle(1'b1, W'(MAX), 4'd0,  "amax_b0");
      cycle(1'b1, 4'd2,  4'd9,  "a2_b9");

      // Idle cycles with undriven operands: valid drops, results hold.
      cycle(1'b0, 'x, 'x, "idle1");
      cycle(1'b0, 'x, 'x, "idle2");
      cycle(1'b0, 'x, 'x, "idle3");

      // Back-to-back accepted pairs.
      cycle(1'b1, 4'd1, 4'd8, "b2b1");
      cycle(1'b1, 4'd8, 4'd1, "b2b2");
      cycle(1'b1, 4'd7, 4'd7, "b2b3");

      // Asynchronous reset between edges, with a pair in flight.
      cycle(1'b1, 4'd11, 4'd6, "pre_rst");
      in_valid = 1'b1;
      a        = 4'd9;
      b        = 4'd3;
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      model_reset();
      check_all("async_rst");
      @(negedge clk);
      check_all("async_rst_hold");
      rst_n    = 1'b1;
      in_valid = 1'b0;
      cycle(1'b0, 4'd4, 4'd2, "post_rst_idle");

      // Exhaustive sweep, also cross-checked against the package helper.
      for (int i = 0; i <= int'(MAX); i++) begin
         for (int j = 0; j <= int'(MAX); j++) begin
            cycle(1'b1, W'(i), W'(j), "sweep");
            pkg_val = abs_diff(MAX_WIDTH'(i), MAX_WIDTH'(j));
            compared++;
            assert (MAX_WIDTH'(out) === pkg_val) else begin
               mismatched++;
               $error("FAIL sweep_pkg a=%0d b=%0d: observed %0d expected %0d", i, j, out, pkg_val);
            end
         end
      end

      // Random traffic with random valid gaps.
      for (int k = 0; k < 200; k++) begin
         ra = W'($urandom);
         rb = W'($urandom);
         cycle(1'($urandom_range(0, 3) != 0), ra, rb, "random");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
